gip_emul_sig_harness: RTL and testbench



---
 rtl/gip_emul_pkg.sv | 43 ++++
 rtl/gip_emul_misr.sv | 60 ++++++
 rtl/gip_emul_sig_harness.sv | 198 +++++++++++++++++++
 tb/tb_gip_emul_sig_harness.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gip_emul_pkg.sv
// rtl/gip_emul_pkg.sv - shared definitions for the GIP emulation stimulus/signature harness
//
// Purpose: FSM state encoding, default LFSR/MISR polynomials and the
// response slice-fold function used by gip_emul_sig_harness and gip_emul_misr.
// Ports: none (package).
package gip_emul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_DONE   = 3'd4
  } gip_emul_state_e;

  localparam logic [31:0] STIM_POLY_DEFAULT = 32'h8020_0003;
  localparam logic [31:0] SIG_POLY_DEFAULT  = 32'h04C1_1DB7;

  // Upper bounds of the generic fold: responses up to 1024 bits, signatures
  // up to 64 bits, at most 64 slices.
  localparam int FOLD_RESP_MAX  = 1024;
  localparam int FOLD_SIG_MAX   = 64;
  localparam int FOLD_SLICE_MAX = 64;

  // XOR of n_slices consecutive sig_w-bit slices of vec, low slice first.
  function automatic logic [FOLD_SIG_MAX-1:0] fold_slices(
    input logic [FOLD_RESP_MAX-1:0] vec,
    input int                       sig_w,
    input int                       n_slices
  );
    logic [FOLD_SIG_MAX-1:0] acc;
    logic [FOLD_SIG_MAX-1:0] mask;
    acc  = '0;
    mask = {FOLD_SIG_MAX{1'b1}} >> (FOLD_SIG_MAX - sig_w);
    for (int j = 0; j < FOLD_SLICE_MAX; j++) begin
      if (j < n_slices) begin
        acc ^= FOLD_SIG_MAX'(vec >> (j * sig_w));
      end
    end
    return acc & mask;
  endfunction

endpackage

// File: rtl/gip_emul_misr.sv
// rtl/gip_emul_misr.sv - multiple-input signature register with clear, capture and shift-out
//
// Purpose: folds a RESP_WIDTH response into SIG_WIDTH bits and compresses it
// into a Galois MISR; can also shift the signature left (0 fill) for unload.
// Priority: rst_i > clear_i > capture_i > shift_i.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset (signature -> 0)
//   clear_i     signature -> 0
//   capture_i   compress response_i into the signature
//   shift_i     shift signature left one bit, 0 fill
//   response_i  response vector (RESP_WIDTH, multiple of SIG_WIDTH)
//   sig_o       current signature
//   sig_next_o  value the signature takes at the next edge (reset excluded)
module gip_emul_misr
  import gip_emul_pkg::*;
#(
  parameter int                    SIG_WIDTH  = 32,
  parameter logic [SIG_WIDTH-1:0]  SIG_POLY   = SIG_WIDTH'(SIG_POLY_DEFAULT),
  parameter int                    RESP_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  capture_i,
  input  logic                  shift_i,
  input  logic [RESP_WIDTH-1:0] response_i,
  output logic [SIG_WIDTH-1:0]  sig_o,
  output logic [SIG_WIDTH-1:0]  sig_next_o
);

  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [SIG_WIDTH-1:0] fold;

  assign fold = SIG_WIDTH'(fold_slices(FOLD_RESP_MAX'(response_i), SIG_WIDTH,
                                       RESP_WIDTH / SIG_WIDTH));

  always_comb begin
    sig_d = sig_q;
    if (clear_i) begin
      sig_d = '0;
    end else if (capture_i) begin
      sig_d = {sig_q[SIG_WIDTH-2:0], 1'b0} ^ (sig_q[SIG_WIDTH-1] ? SIG_POLY : '0) ^ fold;
    end else if (shift_i) begin
      sig_d = {sig_q[SIG_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o      = sig_q;
  assign sig_next_o = sig_d;

endmodule

// File: rtl/gip_emul_sig_harness.sv
// rtl/gip_emul_sig_harness.sv - LFSR stimulus generator and MISR signature harness for GIP emulation
//
// Purpose: drives a wrapped gip_* unit with LFSR stimulus for run_length
// cycles, captures its responses (plus DRAIN_CYCLES of pipeline tail) into a
// MISR signature and optionally unloads the signature serially, MSB first.
// Optional feature macro: GIP_EMUL_SIG_HARNESS_SERIAL_UNLOAD_EN enables the
// UNLOAD state and the serial port; otherwise DRAIN goes straight to DONE,
// the signature is held through DONE and the serial outputs are tied to 0.
// Ports:
//   gip_clock, gip_reset            clock, synchronous active-high reset
//   seed                            switch seed, XORed into each LFSR step
//   start, run_length               launch request (level) and run length
//   stim_enable, stimulus           DUT advance enable and LFSR state
//   response, response_valid        DUT outputs and their qualifier
//   busy, done                      not-IDLE / in-DONE status
//   signature                       MISR state
//   sig_serial, sig_serial_valid    serial signature unload
module gip_emul_sig_harness
  import gip_emul_pkg::*;
#(
  parameter int                    STIM_WIDTH   = 32,
  parameter logic [31:0]           STIM_POLY    = STIM_POLY_DEFAULT,
  parameter logic [STIM_WIDTH-1:0] STIM_INIT    = STIM_WIDTH'(1),
  parameter int                    RESP_WIDTH   = 128,
  parameter int                    SIG_WIDTH    = 32,
  parameter logic [SIG_WIDTH-1:0]  SIG_POLY     = SIG_WIDTH'(SIG_POLY_DEFAULT),
  parameter int                    CNT_WIDTH    = 16,
  parameter int                    DRAIN_CYCLES = 4
) (
  input  logic                  gip_clock,
  input  logic                  gip_reset,
  input  logic [7:0]            seed,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  run_length,
  output logic                  stim_enable,
  output logic [STIM_WIDTH-1:0] stimulus,
  input  logic [RESP_WIDTH-1:0] response,
  input  logic                  response_valid,
  output logic                  busy,
  output logic                  done,
  output logic [SIG_WIDTH-1:0]  signature,
  output logic                  sig_serial,
  output logic                  sig_serial_valid
);

  localparam logic [STIM_WIDTH-1:0] STIM_TAPS = STIM_WIDTH'(STIM_POLY);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  DRAIN_CNT = CNT_WIDTH'(DRAIN_CYCLES);
`ifdef GIP_EMUL_SIG_HARNESS_SERIAL_UNLOAD_EN
  localparam logic [CNT_WIDTH-1:0]  SIG_CNT   = CNT_WIDTH'(SIG_WIDTH);
`endif

  gip_emul_state_e       state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [STIM_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic                  stim_enable_q, busy_q, done_q;
  logic                  misr_clear, misr_capture, misr_shift;
  logic [SIG_WIDTH-1:0]  sig_cur, sig_next;

  // Counter reaching 1 (or already 0, e.g. DRAIN_CYCLES==0) ends a phase.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    misr_clear   = 1'b0;
    misr_capture = 1'b0;
    misr_shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          misr_clear = 1'b1;
          if (run_length == '0) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_CNT;
          end else begin
            state_d = ST_RUN;
            cnt_d   = run_length;
          end
        end
      end
      ST_RUN: begin
        misr_capture = response_valid;
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_CNT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DRAIN: begin
        misr_capture = response_valid;
        if (cnt_q <= CNT_ONE) begin
`ifdef GIP_EMUL_SIG_HARNESS_SERIAL_UNLOAD_EN
          state_d = ST_UNLOAD;
          cnt_d   = SIG_CNT;
`else
          state_d = ST_DONE;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_UNLOAD: begin
        misr_shift = 1'b1;
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Galois step with the seed folded in; an all-zero result would lock up.
  assign lfsr_step = {lfsr_q[STIM_WIDTH-2:0], 1'b0}
                   ^ (lfsr_q[STIM_WIDTH-1] ? STIM_TAPS : '0)
                   ^ STIM_WIDTH'(seed);

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == ST_RUN) begin
      lfsr_d = (lfsr_step == '0) ? STIM_INIT : lfsr_step;
    end
  end

  // Status outputs are registered from the next state so they line up
  // with state_q after each edge.
  always_ff @(posedge gip_clock) begin
    if (gip_reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      lfsr_q        <= STIM_INIT;
      stim_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      stim_enable_q <= (state_d == ST_RUN);
      busy_q        <= (state_d != ST_IDLE);
      done_q        <= (state_d == ST_DONE);
    end
  end

  gip_emul_misr #(
    .SIG_WIDTH  (SIG_WIDTH),
    .SIG_POLY   (SIG_POLY),
    .RESP_WIDTH (RESP_WIDTH)
  ) u_misr (
    .clk_i      (gip_clock),
    .rst_i      (gip_reset),
    .clear_i    (misr_clear),
    .capture_i  (misr_capture),
    .shift_i    (misr_shift),
    .response_i (response),
    .sig_o      (sig_cur),
    .sig_next_o (sig_next)
  );

`ifdef GIP_EMUL_SIG_HARNESS_SERIAL_UNLOAD_EN
  logic sig_serial_q, sig_serial_valid_q;

  // The bit on the pin during an UNLOAD cycle is the MSB the MISR holds in
  // that cycle, i.e. the MSB of its next value as seen one edge earlier.
  always_ff @(posedge gip_clock) begin
    if (gip_reset) begin
      sig_serial_q       <= 1'b0;
      sig_serial_valid_q <= 1'b0;
    end else begin
      sig_serial_q       <= (state_d == ST_UNLOAD) & sig_next[SIG_WIDTH-1];
      sig_serial_valid_q <= (state_d == ST_UNLOAD);
    end
  end

  assign sig_serial       = sig_serial_q;
  assign sig_serial_valid = sig_serial_valid_q;
`else
  logic unused_sig_next;
  assign unused_sig_next  = ^sig_next;
  assign sig_serial       = 1'b0;
  assign sig_serial_valid = 1'b0;
`endif

  assign stim_enable = stim_enable_q;
  assign stimulus    = lfsr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign signature   = sig_cur;

endmodule

// File: tb/tb_gip_emul_sig_harness.sv
// tb/tb_gip_emul_sig_harness.sv - scoreboard bench for gip_emul_sig_harness
module tb_gip_emul_sig_harness;

  localparam int          SW    = 32;
  localparam int          RW    = 64;
  localparam int          DR    = 4;
  localparam int          CW    = 16;
  localparam logic [31:0] SPOLY = 32'h8020_0003;
  localparam logic [31:0] MPOLY = 32'h04C1_1DB7;
`ifdef GIP_EMUL_SIG_HARNESS_SERIAL_UNLOAD_EN
  localparam bit UNLOAD_EN = 1'b1;
`else
  localparam bit UNLOAD_EN = 1'b0;
`endif
  localparam int UN_CYC = UNLOAD_EN ? SW : 0;

  logic          clk = 1'b0;
  logic          gip_reset = 1'b1;
  logic [7:0]    seed = '0;
  logic          start = 1'b0;
  logic [CW-1:0] run_length = '0;
  logic          stim_enable;
  logic [31:0]   stimulus;
  logic [RW-1:0] response = '0;
  logic          response_valid = 1'b0;
  logic          busy, done;
  logic [SW-1:0] signature;
  logic          sig_serial, sig_serial_valid;

  gip_emul_sig_harness #(
    .STIM_WIDTH   (32),
    .STIM_POLY    (SPOLY),
    .STIM_INIT    (32'h1),
    .RESP_WIDTH   (RW),
    .SIG_WIDTH    (SW),
    .SIG_POLY     (MPOLY),
    .CNT_WIDTH    (CW),
    .DRAIN_CYCLES (DR)
  ) dut (
    .gip_clock        (clk),
    .gip_reset        (gip_reset),
    .seed             (seed),
    .start            (start),
    .run_length       (run_length),
    .stim_enable      (stim_enable),
    .stimulus         (stimulus),
    .response         (response),
    .response_valid   (response_valid),
    .busy             (busy),
    .done             (done),
    .signature        (signature),
    .sig_serial       (sig_serial),
    .sig_serial_valid (sig_serial_valid)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_event(input string name, input string detail);
    n_checks++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Reference model: spec arithmetic on plain integers.
  function automatic logic [31:0] m_lfsr_step(input logic [31:0] s, input logic [7:0] sd);
    logic [31:0] n;
    n = (s << 1) ^ (s[31] ? SPOLY : 32'h0) ^ {24'h0, sd};
    return (n == 32'h0) ? 32'h1 : n;
  endfunction

  function automatic logic [31:0] m_fold(input logic [RW-1:0] r);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < RW / SW; i++) f ^= r[i*SW +: SW];
    return f;
  endfunction

  function automatic logic [31:0] m_misr_step(input logic [31:0] m, input logic [31:0] f);
    return (m << 1) ^ (m[31] ? MPOLY : 32'h0) ^ f;
  endfunction

  typedef struct {
    logic [31:0] sig;
    int          lat;
    int          nstim;
  } done_exp_t;

  logic [31:0] m_lfsr;
  logic [31:0] stim_q[$];
  logic        serial_q[$];
  done_exp_t   done_q[$];
  bit          mon_en = 1'b0;

  // Monitor: pops expectations whenever the DUT presents an output.
  int   lat = 0;
  int   nst = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (stim_enable) begin
        nst++;
        if (stim_q.size() == 0) fail_event("stim_unexpected", $sformatf("stim_enable with stimulus %0h", stimulus));
        else check("stimulus", 64'(stimulus), 64'(stim_q.pop_front()));
      end
      if (sig_serial_valid) begin
        if (serial_q.size() == 0) fail_event("serial_unexpected", "sig_serial_valid with no bit pending");
        else check("sig_serial", 64'(sig_serial), 64'(serial_q.pop_front()));
      end
      if (busy && !done) lat++;
      if (done && !done_prev) begin
        if (done_q.size() == 0) begin
          fail_event("done_unexpected", "done rose with no run pending");
        end else begin
          done_exp_t e;
          e = done_q.pop_front();
          check("final_signature", 64'(signature), 64'(e.sig));
          check("run_latency", 64'(lat), 64'(e.lat));
          check("stim_cycles", 64'(nst), 64'(e.nstim));
          check("serial_idle_in_done", {62'h0, sig_serial_valid, sig_serial}, 64'h0);
        end
      end
      if (!busy) begin
        lat = 0;
        nst = 0;
      end
      done_prev = done;
    end
  end

  // mode 0: random responses; 1: single capture of bit 32; 2: all-zero responses
  task automatic do_run(input logic [7:0] sd, input int len, input int mode);
    logic [RW-1:0] resp[$];
    logic          vld[$];
    logic [31:0]   misr;
    done_exp_t     e;
    bit            got;
    int            hold;
    for (int k = 0; k < len + DR; k++) begin
      logic [RW-1:0] r;
      logic          v;
      case ($urandom_range(0, 2))
        0:       r = {$urandom, $urandom};
        1:       r = 64'h1 << $urandom_range(0, RW - 1);
        default: r = '0;
      endcase
      v = ($urandom_range(0, 3) != 0);
      if (mode == 1) v = (k == 0);
      if (mode == 1 && k == 0) r = 64'h0000_0001_0000_0000;
      if (mode == 2) begin
        v = 1'b1;
        r = '0;
      end
      resp.push_back(r);
      vld.push_back(v);
    end
    for (int k = 0; k < len; k++) begin
      stim_q.push_back(m_lfsr);
      m_lfsr = m_lfsr_step(m_lfsr, sd);
    end
    misr = '0;
    for (int k = 0; k < len + DR; k++) if (vld[k]) misr = m_misr_step(misr, m_fold(resp[k]));
    if (UNLOAD_EN) begin
      for (int b = SW - 1; b >= 0; b--) serial_q.push_back(misr[b]);
      e.sig = '0;
    end else begin
      e.sig = misr;
    end
    e.lat   = len + DR + UN_CYC;
    e.nstim = len;
    done_q.push_back(e);

    seed           = sd;
    run_length     = CW'(len);
    start          = 1'b1;
    response_valid = 1'b1;
    response       = {$urandom, $urandom};
    for (int k = 0; k < len + DR; k++) begin
      @(negedge clk);
      response       = resp[k];
      response_valid = vld[k];
      start          = 1'($urandom_range(0, 1));
      run_length     = CW'($urandom);
    end
    got = 1'b0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      start          = 1'($urandom_range(0, 1));
      response_valid = 1'($urandom_range(0, 1));
      response       = {$urandom, $urandom};
    end
    if (!got) fail_event("done_timeout", $sformatf("no done within 200 cycles, len=%0d", len));
    start = 1'b1;
    hold  = $urandom_range(0, 3);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("done_held_while_start", {62'h0, done, stim_enable}, 64'h2);
    end
    start = 1'b0;
    @(negedge clk);
    check("back_to_idle", {62'h0, busy, done}, 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy_done", {62'h0, busy, done}, 64'h0);
    check("reset_stim_enable", 64'(stim_enable), 64'h0);
    check("reset_stimulus", 64'(stimulus), 64'h1);
    check("reset_signature", 64'(signature), 64'h0);
    check("reset_serial", {62'h0, sig_serial_valid, sig_serial}, 64'h0);
    gip_reset = 1'b0;
    m_lfsr    = 32'h1;
    mon_en    = 1'b1;

    do_run(8'h00, 3, 1);
    check("lfsr_after_seed0_run", 64'(stimulus), 64'h8);
    if (!UNLOAD_EN) check("single_capture_signature_held", 64'(signature), 64'h1);
    do_run(8'($urandom), 10, 2);
    check("zero_response_signature", 64'(signature), 64'h0);
    do_run(8'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) do_run(8'($urandom), $urandom_range(0, 20), 0);

    // Reset in the middle of RUN, with the run counter at 5.
    mon_en         = 1'b0;
    seed           = 8'($urandom);
    run_length     = 16'd8;
    start          = 1'b1;
    response_valid = 1'b1;
    response       = {$urandom | 32'h1, $urandom};
    repeat (4) @(negedge clk);
    gip_reset = 1'b1;
    start     = 1'b0;
    @(negedge clk);
    check("midrun_reset_busy", {62'h0, busy, done}, 64'h0);
    check("midrun_reset_stim_enable", 64'(stim_enable), 64'h0);
    check("midrun_reset_stimulus", 64'(stimulus), 64'h1);
    check("midrun_reset_signature", 64'(signature), 64'h0);
    gip_reset      = 1'b0;
    response_valid = 1'b0;
    m_lfsr         = 32'h1;
    @(negedge clk);
    mon_en = 1'b1;

    do_run(8'h01, 1, 0);
    check("lfsr_seed1_first_step", 64'(stimulus), 64'h3);

    repeat (2) @(negedge clk);
    check("queues_drained", 64'(stim_q.size() + serial_q.size() + done_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
